updi_cg_arbiter: RTL

- Two-requester round-robin arbiter that shares the single UPDI command-generator byte port at transaction granularity.
- Each requester presents a transaction: one header byte (repeat count), followed by the data bytes the command generator expects.
  - Header 0: 4 data bytes.
  - Header N (N > 0): 4*N data bytes.
- Once a transaction is granted, it runs to completion without interleaving. A programmable idle gap is then inserted before the next grant.
- Sits between the host-side command sources (debug host, boot sequencer) and the command generator.

---
 rtl/updi_cg_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/updi_cg_arbiter.sv
// Two-requester round-robin arbiter in front of the UPDI command-generator
// byte port. A granted requester owns the port for one whole transaction
// (header byte plus 4*max(H,1) data bytes), after which a fixed idle gap
// separates it from the next grant.
module updi_cg_arbiter #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_r0_data,
    input  logic       i_r0_valid,
    input  logic       i_r0_write,
    output logic       o_r0_ready,
    input  logic [7:0] i_r1_data,
    input  logic       i_r1_valid,
    input  logic       i_r1_write,
    output logic       o_r1_ready,
    output logic [7:0] o_cg_data,
    output logic       o_cg_valid,
    input  logic       i_cg_ready,
    output logic       o_cg_write,
    output logic [1:0] o_grant,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

    logic [1:0] state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;
    logic [9:0] remaining_q, remaining_d;
    logic [3:0] gap_q, gap_d;
    logic       write_q, write_d;

    logic       active;
    logic       owner;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_write;
    logic       xfer;
    logic       pick_r1;

    // Pass-through of the granted requester onto the command-generator port
    always_comb begin
        active     = (state_q == ST_HEADER) || (state_q == ST_DATA);
        owner      = grant_q[1];
        sel_valid  = owner ? i_r1_valid : i_r0_valid;
        sel_data   = owner ? i_r1_data  : i_r0_data;
        sel_write  = owner ? i_r1_write : i_r0_write;
        o_cg_valid = active & sel_valid;
        o_cg_data  = active ? sel_data : 8'h00;
        o_r0_ready = active & grant_q[0] & i_cg_ready;
        o_r1_ready = active & grant_q[1] & i_cg_ready;
        xfer       = o_cg_valid & i_cg_ready;
        o_done     = (state_q == ST_DATA) && xfer && (remaining_q == 10'd1);
        o_busy     = active;
        o_grant    = grant_q;
        o_cg_write = write_q;
    end

    // Arbitration, transaction byte counting and inter-transaction gap
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        remaining_d = remaining_q;
        gap_d       = gap_q;
        write_d     = write_q;
        pick_r1     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_r0_valid || i_r1_valid) begin
                    // On a tie the requester that did not go last wins
                    if (i_r0_valid && i_r1_valid) pick_r1 = ~last_q;
                    else                          pick_r1 = i_r1_valid;
                    grant_d = pick_r1 ? 2'b10 : 2'b01;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (xfer) begin
                    remaining_d = (sel_data == 8'h00) ? 10'd4 : {sel_data, 2'b00};
                    write_d     = sel_write;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    remaining_d = remaining_q - 10'd1;
                    if (remaining_q == 10'd1) begin
                        last_d  = owner;
                        grant_d = 2'b00;
                        gap_d   = GAP_INIT;
                        state_d = ST_GAP;
                    end
                end
            end
            default: begin
                if (gap_q <= 4'd1) state_d = ST_IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
        endcase
    end

    // State registers; reset abandons any transaction in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            remaining_q <= 10'd0;
            gap_q       <= 4'd0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
            write_q     <= write_d;
        end
    end

endmodule
